fp16_mul_arbiter: RTL and testbench

//  Shares one fully pipelined, non-stallable fp16_multiplier between two requesters.

---
 rtl/fp16_mul_arbiter.sv | 151 +++++++++++++++
 tb/tb_fp16_mul_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_mul_arbiter.sv
// Shares one pipelined fp16 multiplier between two requesters (round-robin, or fixed priority when FP16MUL_ARB_FIXED_PRIO_EN is defined).
// Latency: accept to res_valid is MUL_LAT+1 cycles; req*_ready is combinational from valids, pointer and state.
// Backpressure: none on results; requests wait for ready, and the drain input stops all grants.
module fp16_mul_arbiter #(
    parameter int MUL_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [15:0]      req0_a,
    input  logic [15:0]      req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [15:0]      req1_a,
    input  logic [15:0]      req1_b,
    output logic             req1_ready,
    output logic [15:0]      mul_a,
    output logic [15:0]      mul_b,
    input  logic [15:0]      mul_out,
    output logic             res_valid,
    output logic             res_id,
    output logic [15:0]      res_data,
    input  logic             drain,
    output logic             drained,
    output logic [CNT_W-1:0] inflight
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DRAINED} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [15:0]        r_mul_a;
    logic [15:0]        r_mul_b;
    logic [MUL_LAT-1:0] r_tag_v;
    logic [MUL_LAT-1:0] r_tag_id;
    logic               r_res_valid;
    logic               r_res_id;
    logic [15:0]        r_res_data;
    logic [CNT_W-1:0]   r_inflight;
    logic               w_room;
    logic               w_run;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_grant;

    // A full counter only accepts a new op when one retires in the same cycle.
    assign w_room  = (r_inflight != {CNT_W{1'b1}}) || r_res_valid;
    assign w_run   = (r_state == ST_RUN) && !drain && w_room;
    assign w_grant = w_gnt0 || w_gnt1;

`ifdef FP16MUL_ARB_FIXED_PRIO_EN
    assign w_gnt0 = w_run && req0_valid;
    assign w_gnt1 = w_run && req1_valid && !req0_valid;
`else
    logic r_last;  // requester granted most recently

    assign w_gnt0 = w_run && req0_valid && (!req1_valid || r_last);
    assign w_gnt1 = w_run && req1_valid && (!req0_valid || !r_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_gnt1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_a <= '0;
            r_mul_b <= '0;
        end else if (w_gnt0) begin
            r_mul_a <= req0_a;
            r_mul_b <= req0_b;
        end else if (w_gnt1) begin
            r_mul_a <= req1_a;
            r_mul_b <= req1_b;
        end
    end

    // Tag pipe tail lines up with mul_out for the same operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v     <= '0;
            r_tag_id    <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_tag_v[0]  <= w_grant;
            r_tag_id[0] <= w_gnt1;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
            r_res_valid <= r_tag_v[MUL_LAT-1];
            r_res_id    <= r_tag_id[MUL_LAT-1];
            r_res_data  <= mul_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            unique case ({w_grant, r_res_valid})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RUN: begin
                if (drain) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!drain)                                w_state_nxt = ST_RUN;
                else if (r_inflight == '0 && !r_res_valid) w_state_nxt = ST_DRAINED;
            end
            ST_DRAINED: begin
                if (!drain) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign res_valid  = r_res_valid;
    assign res_id     = r_res_id;
    assign res_data   = r_res_data;
    assign drained    = (r_state == ST_DRAINED);
    assign inflight   = r_inflight;

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Directed bench for fp16_mul_arbiter: ordering, latency, saturation, drain and reset.
module tb_fp16_mul_arbiter;
    localparam int MUL_LAT = 10;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic [15:0]      req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic             req0_ready, req1_ready;
    logic [15:0]      mul_a, mul_b, mul_out;
    logic             res_valid, res_id;
    logic [15:0]      res_data;
    logic             drain = 1'b0;
    logic             drained;
    logic [CNT_W-1:0] inflight;

    fp16_mul_arbiter #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
        .drain(drain), .drained(drained), .inflight(inflight)
    );

    always #5 clk = ~clk;

    // Operand table with hand-computed exact products.
    logic [15:0] t_a [8] = '{16'h3C00, 16'h3E00, 16'h4000, 16'h3E00, 16'hC000, 16'h4200, 16'h3800, 16'h4400};
    logic [15:0] t_b [8] = '{16'h4000, 16'h4000, 16'h4000, 16'h3E00, 16'h3800, 16'h4200, 16'h3800, 16'hBC00};
    logic [15:0] t_p [8] = '{16'h4000, 16'h4200, 16'h4400, 16'h4080, 16'hBC00, 16'h4880, 16'h3400, 16'hC400};

    // Multiplier stand-in for normal operands; its output lines up with the DUT tag tail.
    function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
        logic [21:0] p;
        logic [5:0]  e;
        logic [9:0]  m;
        p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        e = 6'(a[14:10]) + 6'(b[14:10]) - 6'd15;
        if (p[21]) begin
            m = p[20:11];
            e = e + 6'd1;
        end else begin
            m = p[19:10];
        end
        if (a[14:0] == 15'd0 || b[14:0] == 15'd0) return {a[15] ^ b[15], 15'd0};
        return {a[15] ^ b[15], e[4:0], m};
    endfunction

    logic [15:0] mpipe [MUL_LAT-1];
    always @(posedge clk) begin
        mpipe[0] <= fmul(mul_a, mul_b);
        for (int i = 1; i < MUL_LAT - 1; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_out = mpipe[MUL_LAT-2];

    typedef struct {
        logic        id;
        logic [15:0] p;
        int          c;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_res = 0;
    int   i0 = 0, i1 = 0;
    int   max_if = 0;
    logic g0, g1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (q.size() == 0) begin
                chk("res_spurious", 32'd1, 32'd0);
            end else begin
                me = q.pop_front();
                chk("res_id", 32'(res_id), 32'(me.id));
                chk("res_data", 32'(res_data), 32'(me.p));
                chk("res_lat", 32'(cyc - me.c), 32'(MUL_LAT + 1));
                n_res++;
            end
        end
    end

    // One clock: sample grants mid-cycle, record expectations, then advance requester operands.
    task automatic tick();
        @(negedge clk);
        g0 = req0_ready;
        g1 = req1_ready;
        if (int'(inflight) > max_if) max_if = int'(inflight);
        if (g0) begin
            q.push_back('{1'b0, t_p[i0 % 8], cyc});
            i0++;
        end
        if (g1) begin
            q.push_back('{1'b1, t_p[(i1 + 3) % 8], cyc});
            i1++;
        end
        @(posedge clk);
        #1;
        req0_a = t_a[i0 % 8];
        req0_b = t_b[i0 % 8];
        req1_a = t_a[(i1 + 3) % 8];
        req1_b = t_b[(i1 + 3) % 8];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain = 1'b0;
        i0 = 0;
        i1 = 0;
        req0_a = t_a[0];
        req0_b = t_b[0];
        req1_a = t_a[3];
        req1_b = t_b[3];
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        int ng, nr;
        logic any;

        // 1: reset state and a single op
        do_reset();
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_id", 32'(res_id), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_mul_a", 32'(mul_a), 0);
        chk("rst_mul_b", 32'(mul_b), 0);
        chk("rst_inflight", 32'(inflight), 0);
        chk("rst_drained", 32'(drained), 0);
        req0_valid = 1'b1;
        tick();
        chk("t1_rdy0", 32'(g0), 1);
        chk("t1_rdy1", 32'(g1), 0);
        chk("t1_mul_a", 32'(mul_a), 32'h3C00);
        chk("t1_mul_b", 32'(mul_b), 32'h4000);
        req0_valid = 1'b0;
        tick();
        chk("t1_mul_a_hold", 32'(mul_a), 32'h3C00);
        repeat (12) tick();
        chk("t1_pending", 32'(q.size()), 0);
        chk("t1_n_res", 32'(n_res), 1);
        chk("t1_inflight", 32'(inflight), 0);

        // 2: both valid for 8 cycles
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
`ifdef FP16MUL_ARB_FIXED_PRIO_EN
            chk("t2_rdy0", 32'(g0), 1);
            chk("t2_rdy1", 32'(g1), 0);
`else
            chk("t2_rdy0", 32'(g0), 32'(k % 2 == 0));
            chk("t2_rdy1", 32'(g1), 32'(k % 2 == 1));
`endif
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (13) tick();
        chk("t2_pending", 32'(q.size()), 0);

        // 3: back-to-back stream of 20 ops
        do_reset();
        max_if = 0;
        nr = n_res;
        ng = 0;
        req0_valid = 1'b1;
        repeat (20) begin
            tick();
            ng += int'(g0);
        end
        req0_valid = 1'b0;
        repeat (13) tick();
        chk("t3_grants", 32'(ng), 20);
        chk("t3_max_inflight", 32'(max_if), 32'(MUL_LAT + 1));
        chk("t3_results", 32'(n_res - nr), 20);
        chk("t3_pending", 32'(q.size()), 0);

        // 4: drain with 5 in flight
        do_reset();
        req0_valid = 1'b1;
        repeat (5) tick();
        req1_valid = 1'b1;
        drain = 1'b1;
        tick();
        chk("t4_rdy_drain", 32'({g0, g1}), 0);
        chk("t4_inflight", 32'(inflight), 5);
        chk("t4_not_drained", 32'(drained), 0);
        any = 1'b0;
        repeat (15) begin
            tick();
            any = any | g0 | g1;
        end
        chk("t4_no_grant", 32'(any), 0);
        chk("t4_drained", 32'(drained), 1);
        chk("t4_inflight_0", 32'(inflight), 0);
        chk("t4_pending", 32'(q.size()), 0);
        drain = 1'b0;
        tick();
        chk("t4_resume_wait", 32'({g0, g1}), 0);
        chk("t4_run", 32'(drained), 0);
        tick();
`ifdef FP16MUL_ARB_FIXED_PRIO_EN
        chk("t4_resume", 32'({g0, g1}), 32'b10);
`else
        chk("t4_resume", 32'({g0, g1}), 32'b01);
`endif
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (13) tick();
        chk("t4_pending_end", 32'(q.size()), 0);

        // 5: reset with 6 in flight
        do_reset();
        req0_valid = 1'b1;
        repeat (6) tick();
        req0_valid = 1'b0;
        chk("t5_inflight_pre", 32'(inflight), 6);
        rst_n = 1'b0;
        #2;
        chk("t5_res_valid", 32'(res_valid), 0);
        chk("t5_inflight", 32'(inflight), 0);
        chk("t5_mul_a", 32'(mul_a), 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        nr = n_res;
        any = 1'b0;
        repeat (15) begin
            tick();
            any = any | res_valid;
        end
        chk("t5_no_stale", 32'(n_res - nr), 0);
        chk("t5_no_res_valid", 32'(any), 0);
        chk("t5_drained", 32'(drained), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
